// File: rtl/rv32_ctrl_pkg.sv
//==============================================================================
// Module      : rv32_ctrl_pkg
// Description : Shared RV32IM decode constants: ALU select codes, major opcodes,
//               branch/jump encodings and the base-integer funct3 -> ALU map.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32_ctrl_pkg;

    localparam logic [4:0] C_ALU_FWD    = 5'd0;
    localparam logic [4:0] C_ALU_ADD    = 5'd1;
    localparam logic [4:0] C_ALU_SUB    = 5'd2;
    localparam logic [4:0] C_ALU_SLL    = 5'd3;
    localparam logic [4:0] C_ALU_SLT    = 5'd4;
    localparam logic [4:0] C_ALU_SLTU   = 5'd5;
    localparam logic [4:0] C_ALU_XOR    = 5'd6;
    localparam logic [4:0] C_ALU_SRL    = 5'd7;
    localparam logic [4:0] C_ALU_SRA    = 5'd8;
    localparam logic [4:0] C_ALU_OR     = 5'd9;
    localparam logic [4:0] C_ALU_AND    = 5'd10;
    localparam logic [4:0] C_ALU_MUL    = 5'd11;
    localparam logic [4:0] C_ALU_MULH   = 5'd12;
    localparam logic [4:0] C_ALU_MULHSU = 5'd13;
    localparam logic [4:0] C_ALU_MULHU  = 5'd14;
    localparam logic [4:0] C_ALU_DIV    = 5'd15;
    localparam logic [4:0] C_ALU_DIVU   = 5'd16;
    localparam logic [4:0] C_ALU_REM    = 5'd17;
    localparam logic [4:0] C_ALU_REMU   = 5'd18;

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] C_BR_NONE = 3'd0;
    localparam logic [2:0] C_BR_BEQ  = 3'd1;
    localparam logic [2:0] C_BR_BNE  = 3'd2;
    localparam logic [2:0] C_BR_BLT  = 3'd3;
    localparam logic [2:0] C_BR_BGE  = 3'd4;
    localparam logic [2:0] C_BR_BLTU = 3'd5;
    localparam logic [2:0] C_BR_BGEU = 3'd6;

    localparam logic [1:0] C_JMP_NONE = 2'd0;
    localparam logic [1:0] C_JMP_JAL  = 2'd1;
    localparam logic [1:0] C_JMP_JALR = 2'd2;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
        logic [4:0] sel;
        case (funct3)
            3'd0:    sel = alt ? C_ALU_SUB : C_ALU_ADD;
            3'd1:    sel = C_ALU_SLL;
            3'd2:    sel = C_ALU_SLT;
            3'd3:    sel = C_ALU_SLTU;
            3'd4:    sel = C_ALU_XOR;
            3'd5:    sel = alt ? C_ALU_SRA : C_ALU_SRL;
            3'd6:    sel = C_ALU_OR;
            default: sel = C_ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_imm_gen.sv
//==============================================================================
// Module      : rv32_imm_gen
// Description : Combinational RV32 immediate extraction (I/S/B/U/J), selected
//               by major opcode; zero for R-type and unknown opcodes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rv32_imm_gen
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            C_OPC_OP_IMM, C_OPC_LOAD, C_OPC_JALR:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            C_OPC_STORE:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            C_OPC_BRANCH:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            C_OPC_LUI, C_OPC_AUIPC:
                o_imm = {i_instr[31:12], 12'b0};
            C_OPC_JAL:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_alu_ctrl_stage.sv
//==============================================================================
// Module      : id_alu_ctrl_stage
// Description : RV32IM decode stage with valid/ready ID/EX register and flush.
//               Optional macro RV32M_DECODE_EN enables M-extension decode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_alu_ctrl_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] alu_select,
    output logic             op1_pc,
    output logic             op2_imm,
    output logic [XLEN-1:0]  imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       mem_funct3,
    output logic [2:0]       branch_type,
    output logic [1:0]       jump,
    output logic             illegal,
    output logic [XLEN-1:0]  pc_out
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_raw;
    logic [4:0]  w_sel;
    logic        w_op1_pc;
    logic        w_op2_imm;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic [2:0]  w_mem_funct3;
    logic [2:0]  w_branch_type;
    logic [1:0]  w_jump;
    logic        w_illegal;
    logic        w_capture;

    logic             r_valid;
    logic [SEL_W-1:0] r_sel;
    logic             r_op1_pc;
    logic             r_op2_imm;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [2:0]       r_mem_funct3;
    logic [2:0]       r_branch_type;
    logic [1:0]       r_jump;
    logic             r_illegal;
    logic [XLEN-1:0]  r_pc;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    rv32_imm_gen u_imm_gen (
        .i_instr (instr),
        .o_imm   (w_imm_raw)
    );

    always_comb begin
        w_sel         = C_ALU_FWD;
        w_op1_pc      = 1'b0;
        w_op2_imm     = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_funct3  = 3'd0;
        w_branch_type = C_BR_NONE;
        w_jump        = C_JMP_NONE;
        w_illegal     = 1'b0;

        if (instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                C_OPC_OP: begin
                    w_reg_write = 1'b1;
                    if (w_funct7 == 7'b0000000) begin
                        w_sel = alu_base(w_funct3, 1'b0);
                    end else if (w_funct7 == 7'b0100000 &&
                                 (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                        w_sel = alu_base(w_funct3, 1'b1);
                    end else if (w_funct7 == 7'b0000001) begin
`ifdef RV32M_DECODE_EN
                        w_sel = C_ALU_MUL + {2'b00, w_funct3};
`else
                        w_illegal = 1'b1;
`endif
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                C_OPC_OP_IMM: begin
                    w_reg_write = 1'b1;
                    w_op2_imm   = 1'b1;
                    // shift-immediates reuse the funct7 slot as a qualifier
                    if (w_funct3 == 3'b001) begin
                        if (w_funct7 == 7'b0000000) w_sel = C_ALU_SLL;
                        else                        w_illegal = 1'b1;
                    end else if (w_funct3 == 3'b101) begin
                        if (w_funct7 == 7'b0000000)      w_sel = C_ALU_SRL;
                        else if (w_funct7 == 7'b0100000) w_sel = C_ALU_SRA;
                        else                             w_illegal = 1'b1;
                    end else begin
                        w_sel = alu_base(w_funct3, 1'b0);
                    end
                end
                C_OPC_LOAD: begin
                    w_sel        = C_ALU_ADD;
                    w_op2_imm    = 1'b1;
                    w_reg_write  = 1'b1;
                    w_mem_read   = 1'b1;
                    w_mem_funct3 = w_funct3;
                    if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7)
                        w_illegal = 1'b1;
                end
                C_OPC_STORE: begin
                    w_sel        = C_ALU_ADD;
                    w_op2_imm    = 1'b1;
                    w_mem_write  = 1'b1;
                    w_mem_funct3 = w_funct3;
                    if (w_funct3 > 3'd2) w_illegal = 1'b1;
                end
                C_OPC_BRANCH: begin
                    w_sel = C_ALU_SUB;
                    case (w_funct3)
                        3'd0:    w_branch_type = C_BR_BEQ;
                        3'd1:    w_branch_type = C_BR_BNE;
                        3'd4:    w_branch_type = C_BR_BLT;
                        3'd5:    w_branch_type = C_BR_BGE;
                        3'd6:    w_branch_type = C_BR_BLTU;
                        3'd7:    w_branch_type = C_BR_BGEU;
                        default: w_illegal     = 1'b1;
                    endcase
                end
                C_OPC_JAL: begin
                    w_sel       = C_ALU_ADD;
                    w_op1_pc    = 1'b1;
                    w_op2_imm   = 1'b1;
                    w_reg_write = 1'b1;
                    w_jump      = C_JMP_JAL;
                end
                C_OPC_JALR: begin
                    w_sel       = C_ALU_ADD;
                    w_op2_imm   = 1'b1;
                    w_reg_write = 1'b1;
                    w_jump      = C_JMP_JALR;
                    if (w_funct3 != 3'd0) w_illegal = 1'b1;
                end
                C_OPC_LUI: begin
                    w_sel       = C_ALU_FWD;
                    w_op2_imm   = 1'b1;
                    w_reg_write = 1'b1;
                end
                C_OPC_AUIPC: begin
                    w_sel       = C_ALU_ADD;
                    w_op1_pc    = 1'b1;
                    w_op2_imm   = 1'b1;
                    w_reg_write = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end

        // an undecodable word must never reach EX with side effects
        if (w_illegal) begin
            w_sel         = C_ALU_FWD;
            w_op1_pc      = 1'b0;
            w_op2_imm     = 1'b0;
            w_reg_write   = 1'b0;
            w_mem_read    = 1'b0;
            w_mem_write   = 1'b0;
            w_mem_funct3  = 3'd0;
            w_branch_type = C_BR_NONE;
            w_jump        = C_JMP_NONE;
        end

        if (instr[11:7] == 5'd0) w_reg_write = 1'b0;
    end

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_sel         <= '0;
            r_op1_pc      <= 1'b0;
            r_op2_imm     <= 1'b0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_funct3  <= '0;
            r_branch_type <= '0;
            r_jump        <= '0;
            r_illegal     <= 1'b0;
            r_pc          <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid       <= 1'b1;
            r_sel         <= SEL_W'(w_sel);
            r_op1_pc      <= w_op1_pc;
            r_op2_imm     <= w_op2_imm;
            r_imm         <= w_illegal ? '0 : w_imm_raw;
            r_rs1         <= instr[19:15];
            r_rs2         <= instr[24:20];
            r_rd          <= instr[11:7];
            r_reg_write   <= w_reg_write;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_mem_funct3  <= w_mem_funct3;
            r_branch_type <= w_branch_type;
            r_jump        <= w_jump;
            r_illegal     <= w_illegal;
            r_pc          <= pc_in;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign alu_select  = r_sel;
    assign op1_pc      = r_op1_pc;
    assign op2_imm     = r_op2_imm;
    assign imm         = r_imm;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign reg_write   = r_reg_write;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_funct3  = r_mem_funct3;
    assign branch_type = r_branch_type;
    assign jump        = r_jump;
    assign illegal     = r_illegal;
    assign pc_out      = r_pc;

endmodule

`default_nettype wire
